free_list_allocator: RTL and testbench
======================================

FREE_LIST_ALLOCATOR -- requirements
Module: free_list_allocator

Interface
REQ-001 SHALL have parameter NUM_PREGS, default 64, total physical registers; the p_reg width equals $clog2(NUM_PREGS).
REQ-002 SHALL have parameter NUM_AREGS, default 32, architectural registers mapped at reset; free-list depth DEPTH = NUM_PREGS-NUM_AREGS.
REQ-003 SHALL have port i_clk  input  1  rising-edge clock.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_alloc_req  input  2  per-slot request for a destination preg, where bit i is rename slot i.
REQ-006 SHALL have port o_alloc_ready  output  1  high when two or more entries are free.
REQ-007 SHALL have port o_free_pregs  output  p_reg[0:1]  compacted grant to rename slots 0 and 1.
REQ-008 SHALL have port i_free_valid  input  2  per-slot commit release valid.
REQ-009 SHALL have port i_free_pregs  input  p_reg[0:1]  pregs released at commit.
REQ-010 SHALL have port o_err  output  1  sticky overflow/underflow error flag.

Function
REQ-011 SHALL store free pregs in a circular buffer of DEPTH entries, with head/tail pointers carrying a wrap bit and an occupancy count of width $clog2(DEPTH)+1.
REQ-012 SHALL drive o_alloc_ready = (count >= 2) combinationally; allocation is all-or-nothing and ignores per-slot need.
REQ-013 SHALL drive o_free_pregs[0] = buf[head], and o_free_pregs[1] = buf[head+1] when i_alloc_req[0] is high, else buf[head]; this is combinational with zero latency.
REQ-014 SHALL pop, on a rising edge with o_alloc_ready high, popcount(i_alloc_req) entries: head advances 0, 1 or 2, modulo DEPTH.
REQ-015 SHALL pop nothing when i_alloc_req is nonzero and o_alloc_ready is low; rename stalls, and this is not an error.
REQ-016 SHALL push each valid i_free_pregs entry at tail in slot order (slot 0 first), with tail advancing 0, 1 or 2, modulo DEPTH.
REQ-017 SHALL silently drop a release of preg 0, which is never allocated or pushed.
REQ-018 SHALL make pushed entries allocatable no earlier than the next cycle; there is no same-cycle free-to-alloc bypass.
REQ-019 SHALL update count on simultaneous push/pop as count + pushes - pops in one cycle, with no priority conflict.
REQ-020 SHALL handle overflow (count - pops + pushes > DEPTH) by discarding the excess pushes, leaving count at DEPTH and setting o_err.
REQ-021 SHALL wrap pointers from DEPTH-1 to 0 and toggle the wrap bit; full when the indices are equal and the wrap bits differ, empty when the indices are equal and the wrap bits are equal.

Reset
REQ-022 SHALL, on i_rst_n low, asynchronously load buf[k] = NUM_AREGS+k for k = 0..DEPTH-1, set head = 0 (wrap 0), tail = 0 (wrap 1), count = DEPTH and o_err = 0.
REQ-023 SHALL, after reset with default parameters, drive o_alloc_ready = 1 and o_free_pregs = {32,33} when i_alloc_req = 2'b11.
REQ-024 SHALL abandon any in-flight push/pop when reset is asserted mid-operation; state returns to REQ-022 with no partial update.
REQ-025 SHALL clear o_err only by reset.

Configuration
REQ-026 SHALL, with macro FREE_LIST_DUP_CHECK_EN defined, keep a NUM_PREGS-bit in-list bitmap, set on push and cleared on pop.
REQ-027 SHALL, with the macro defined, drop a release of a preg whose bit is already set (double free) and set o_err; same-cycle slot 0/slot 1 duplicates push once and set o_err.
REQ-028 SHALL, without the macro, omit the bitmap and push every valid nonzero release unchecked.

Verification
REQ-029 SHALL cover: reset, then i_alloc_req = 2'b11 for 16 cycles -> grants {32,33},{34,35}…{62,63}; count 0; o_alloc_ready low on the 17th cycle; head wraps to 0.
REQ-030 SHALL cover: from reset, i_alloc_req = 2'b10 -> o_free_pregs[1] = 32 and count 31; then 2'b01 -> o_free_pregs[0] = 33.
REQ-031 SHALL cover: empty list, same cycle i_free_valid = 2'b11 with {40,41} and i_alloc_req = 2'b11 -> no grant; next cycle o_alloc_ready = 1, grant {40,41}.
REQ-032 SHALL cover: full list, release preg 5 -> count stays 32 and o_err = 1; release preg 0 -> ignored, o_err unchanged.
REQ-033 SHALL cover: with FREE_LIST_DUP_CHECK_EN, allocate 32 and release 32 twice -> second release dropped, o_err = 1, count +1 only.
REQ-034 SHALL cover: assert i_rst_n low mid-cycle during alloc plus free -> outputs immediately match REQ-022/REQ-023.

Source files
------------

// File: rtl/free_list_allocator.sv
// Rename free list: circular buffer of free physical registers, two grants per cycle.
// Define FREE_LIST_DUP_CHECK_EN to add an in-list bitmap that rejects double frees.
module free_list_allocator #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [1:0]                   i_alloc_req,
    output logic                         o_alloc_ready,
    output logic [$clog2(NUM_PREGS)-1:0] o_free_pregs [0:1],
    input  logic [1:0]                   i_free_valid,
    input  logic [$clog2(NUM_PREGS)-1:0] i_free_pregs [0:1],
    output logic                         o_err
);

    localparam int PW    = $clog2(NUM_PREGS);
    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int IW    = $clog2(DEPTH);
    localparam int CW    = IW + 1;

    typedef logic [PW-1:0] preg_t;
    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   ptr_t;

    preg_t          fl_q [DEPTH];
    ptr_t           head_q;
    ptr_t           tail_q;
    logic [CW-1:0]  count_q;
    logic           err_q;

    logic [1:0]     pop_n;
    logic [1:0]     push_n;
    logic [CW:0]    space;
    logic           rel0, rel1;
    logic           cand0, cand1;
    logic           acc0, acc1;
    logic           ovf;
    logic           dup_err;
    idx_t           head_idx, head1_idx;
    idx_t           wr0_idx, wr1_idx;

    function automatic idx_t inc_idx(idx_t i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    // Advance by 0..2 modulo DEPTH, toggling the wrap bit on crossing.
    function automatic ptr_t adv(ptr_t p, logic [1:0] n);
        logic [IW+1:0] s;
        logic          w;
        s = {2'b00, p[IW-1:0]} + {{IW{1'b0}}, n};
        w = p[IW];
        if (s >= (IW+2)'(DEPTH)) begin
            s = s - (IW+2)'(DEPTH);
            w = ~w;
        end
        return {w, s[IW-1:0]};
    endfunction

    assign head_idx  = head_q[IW-1:0];
    assign head1_idx = inc_idx(head_idx);

    assign o_alloc_ready   = (count_q >= CW'(2));
    assign o_free_pregs[0] = fl_q[head_idx];
    assign o_free_pregs[1] = i_alloc_req[0] ? fl_q[head1_idx]
                                            : fl_q[head_idx];
    assign o_err           = err_q;

    assign pop_n = o_alloc_ready
                 ? ({1'b0, i_alloc_req[0]} + {1'b0, i_alloc_req[1]})
                 : 2'd0;

    assign rel0 = i_free_valid[0] && (i_free_pregs[0] != '0);
    assign rel1 = i_free_valid[1] && (i_free_pregs[1] != '0);

`ifdef FREE_LIST_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] inlist_q;
    logic                 dup0, dup1;

    assign dup0 = rel0 && inlist_q[i_free_pregs[0]];
    assign dup1 = rel1 && (inlist_q[i_free_pregs[1]] ||
                           (rel0 && (i_free_pregs[1] == i_free_pregs[0])));
    assign cand0   = rel0 && !dup0;
    assign cand1   = rel1 && !dup1;
    assign dup_err = dup0 || dup1;

    // Popped and pushed pregs never coincide: a push needs a clear bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_PREGS; k++) begin
                inlist_q[k] <= (k >= NUM_AREGS);
            end
        end else begin
            if (pop_n != 2'd0) begin
                inlist_q[fl_q[head_idx]] <= 1'b0;
            end
            if (pop_n == 2'd2) begin
                inlist_q[fl_q[head1_idx]] <= 1'b0;
            end
            if (acc0) begin
                inlist_q[i_free_pregs[0]] <= 1'b1;
            end
            if (acc1) begin
                inlist_q[i_free_pregs[1]] <= 1'b1;
            end
        end
    end
`else
    assign cand0   = rel0;
    assign cand1   = rel1;
    assign dup_err = 1'b0;
`endif

    // Slots freed by this cycle's pops are reusable by this cycle's pushes.
    assign space = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop_n);

    assign acc0 = cand0 && (space >= (CW+1)'(1));
    assign acc1 = cand1 && (acc0 ? (space >= (CW+1)'(2))
                                 : (space >= (CW+1)'(1)));
    assign ovf  = (cand0 && !acc0) || (cand1 && !acc1);

    assign push_n  = {1'b0, acc0} + {1'b0, acc1};
    assign wr0_idx = tail_q[IW-1:0];
    assign wr1_idx = acc0 ? inc_idx(tail_q[IW-1:0]) : tail_q[IW-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                fl_q[k] <= PW'(NUM_AREGS + k);
            end
            head_q  <= '0;
            tail_q  <= {1'b1, {IW{1'b0}}};
            count_q <= CW'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            if (acc0) begin
                fl_q[wr0_idx] <= i_free_pregs[0];
            end
            if (acc1) begin
                fl_q[wr1_idx] <= i_free_pregs[1];
            end
            head_q  <= adv(head_q, pop_n);
            tail_q  <= adv(tail_q, push_n);
            count_q <= count_q - CW'(pop_n) + CW'(push_n);
            err_q   <= err_q | ovf | dup_err;
        end
    end

endmodule

// File: tb/tb_free_list_allocator.sv
// Bench for free_list_allocator: queue model checked every negedge,
// plus directed vectors with literal expectations.
module tb_free_list_allocator;

    localparam int DEPTH = 32;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic       ready;
    logic [5:0] fp  [0:1];
    logic [1:0] fv;
    logic [5:0] fin [0:1];
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;

    int fq[$];
    int snap[$];
    int merr;
    int first_rel;

    free_list_allocator dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_alloc_req   (req),
        .o_alloc_ready (ready),
        .o_free_pregs  (fp),
        .i_free_valid  (fv),
        .i_free_pregs  (fin),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_snap(int p);
        foreach (snap[i]) if (snap[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Model: the free list as a FIFO queue of preg numbers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            for (int k = 0; k < DEPTH; k++) fq.push_back(32 + k);
            merr = 0;
        end else begin
            snap = fq;
            first_rel = -1;
            if (fq.size() >= 2) begin
                repeat (int'(req[0]) + int'(req[1])) void'(fq.pop_front());
            end
            for (int s = 0; s < 2; s++) begin
                if (fv[s] && fin[s] != 0) begin
                    bit drop;
                    drop = 0;
`ifdef FREE_LIST_DUP_CHECK_EN
                    if (in_snap(int'(fin[s])) || int'(fin[s]) == first_rel) begin
                        drop = 1;
                        merr = 1;
                    end
`endif
                    if (!drop) begin
                        if (fq.size() >= DEPTH) merr = 1;
                        else fq.push_back(int'(fin[s]));
                    end
                    if (s == 0) first_rel = int'(fin[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ready", 32'(ready), 32'(fq.size() >= 2));
            chk("err", 32'(err), 32'(merr));
            chk("count", 32'(dut.count_q), 32'(fq.size()));
            if (fq.size() >= 1) chk("grant0", 32'(fp[0]), 32'(fq[0]));
            if (fq.size() >= 2) begin
                chk("grant1", 32'(fp[1]), 32'(req[0] ? fq[1] : fq[0]));
            end else if (fq.size() == 1 && !req[0]) begin
                chk("grant1", 32'(fp[1]), 32'(fq[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] v,
                         input int a, input int b);
        req    = r;
        fv     = v;
        fin[0] = 6'(a);
        fin[1] = 6'(b);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 0, 0);
        step();
        step();
        #1;
        chk("rst_ready", 32'(ready), 1);
        chk("rst_count", 32'(dut.count_q), 32);
        chk("rst_err", 32'(err), 0);
        req = 2'b11;
        #1;
        chk("rst_g0", 32'(fp[0]), 32);
        chk("rst_g1", 32'(fp[1]), 33);
        rst_n   = 1'b1;
        started = 1;

        for (int i = 0; i < 16; i++) begin
            chk("drain_g0", 32'(fp[0]), 32'(32 + 2 * i));
            chk("drain_g1", 32'(fp[1]), 32'(33 + 2 * i));
            step();
        end
        #1;
        chk("drain_ready", 32'(ready), 0);
        chk("drain_count", 32'(dut.count_q), 0);
        chk("drain_head", 32'(dut.head_q), 32);

        drive(2'b11, 2'b11, 40, 41);
        #1;
        chk("bypass_ready", 32'(ready), 0);
        step();
        fv = 2'b00;
        #1;
        chk("nextcyc_ready", 32'(ready), 1);
        chk("nextcyc_g0", 32'(fp[0]), 40);
        chk("nextcyc_g1", 32'(fp[1]), 41);
        step();
        req = 2'b00;

        for (int i = 0; i < 16; i++) begin
            drive(2'b00, 2'b11, 63 - 2 * i, 62 - 2 * i);
            step();
        end
        fv = 2'b00;
        #1;
        chk("refill_count", 32'(dut.count_q), 32);
        chk("refill_g0", 32'(fp[0]), 63);

        drive(2'b00, 2'b01, 0, 0);
        step();
        fv = 2'b00;
        #1;
        chk("rel0_err", 32'(err), 0);
        chk("rel0_count", 32'(dut.count_q), 32);
        drive(2'b00, 2'b01, 5, 0);
        step();
        fv = 2'b00;
        #1;
        chk("ovf_err", 32'(err), 1);
        chk("ovf_count", 32'(dut.count_q), 32);
        drive(2'b00, 2'b01, 0, 0);
        step();
        fv = 2'b00;
        #1;
        chk("sticky_err", 32'(err), 1);

        rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(err), 0);
        step();
        rst_n = 1'b1;

        req = 2'b10;
        #1;
        chk("slot1_g1", 32'(fp[1]), 32);
        step();
        #1;
        chk("slot1_count", 32'(dut.count_q), 31);
        req = 2'b01;
        #1;
        chk("slot0_g0", 32'(fp[0]), 33);
        step();
        drive(2'b11, 2'b11, 32, 33);
        step();
        #1;
        chk("pushpop_count", 32'(dut.count_q), 30);
        drive(2'b00, 2'b10, 0, 7);
        step();
        drive(2'b00, 2'b00, 0, 0);
        #1;
        chk("slot1rel_count", 32'(dut.count_q), 31);

        for (int i = 0; i < 40; i++) begin
            drive(2'(i % 4), 2'((i * 3) % 4),
                  (i % 7 == 0) ? 0 : 1 + (i % 29), 2 + ((i * 5) % 29));
            step();
        end
        drive(2'b00, 2'b00, 0, 0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 2'b11;
        step();
        step();
        drive(2'b00, 2'b01, 32, 0);
        step();
        step();
        fv = 2'b00;
        #1;
`ifdef FREE_LIST_DUP_CHECK_EN
        chk("dup_count", 32'(dut.count_q), 29);
        chk("dup_err", 32'(err), 1);
`else
        chk("nodup_count", 32'(dut.count_q), 30);
        chk("nodup_err", 32'(err), 0);
`endif

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 2'b11;
        step();
        drive(2'b00, 2'b11, 9, 9);
        step();
        fv = 2'b00;
        #1;
`ifdef FREE_LIST_DUP_CHECK_EN
        chk("same_count", 32'(dut.count_q), 31);
        chk("same_err", 32'(err), 1);
`else
        chk("same_count", 32'(dut.count_q), 32);
        chk("same_err", 32'(err), 0);
`endif

        drive(2'b11, 2'b11, 5, 6);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(ready), 1);
        chk("mid_g0", 32'(fp[0]), 32);
        chk("mid_g1", 32'(fp[1]), 33);
        chk("mid_err", 32'(err), 0);
        chk("mid_count", 32'(dut.count_q), 32);
        step();
        rst_n = 1'b1;
        drive(2'b00, 2'b00, 0, 0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
